pipe_slot_arbiter: RTL and testbench

Round-robin arbiter and in-flight tracker that shares one fixed-latency datapath (a bitnet compute stage paired with a `signal_delay`-style valid line) among NUM_REQ requesters. It grants at most one issue per cycle and tags each issue with its requester ID. The tag travels through a LATENCY-deep shadow pipeline, and the block pulses a per-requester completion when the op exits. Per-requester outstanding counters cap each requester's in-flight ops.

---
 rtl/pipe_slot_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_pipe_slot_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_slot_arbiter.sv
// Round-robin issue arbiter with a LATENCY-deep ID shadow pipeline and per-requester in-flight caps.
// Optional build macro PIPE_SLOT_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module pipe_slot_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 3,
    parameter  int MAX_OUT = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               hold_in,
    input  logic               flush_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic               issue_valid_out,
    output logic [IDW-1:0]     issue_id_out,
    output logic               pipe_en_out,
    output logic [NUM_REQ-1:0] done_out,
    output logic [IDW-1:0]     done_id_out,
    output logic               busy_out
);

    localparam int             CW        = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_OUT);
    localparam logic [IDW:0]   NUM_REQ_W = (IDW + 1)'(NUM_REQ);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [LATENCY-1:0] stage_vld_q, stage_vld_d;
    logic [IDW-1:0]     stage_id_q [LATENCY];
    logic [IDW-1:0]     stage_id_d [LATENCY];
    logic [CW-1:0]      cnt_q [NUM_REQ];
    logic [CW-1:0]      cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rr_elig;
    logic               rr_found;
    logic [IDW-1:0]     rr_id;
    logic [IDW:0]       scan;
    logic [IDW:0]       ptr_nxt;
    logic               issue_valid;
    logic [IDW-1:0]     issue_id;
    logic               done_valid;
    logic [IDW-1:0]     tail_id;
    logic [NUM_REQ-1:0] inc_vec;
    logic [NUM_REQ-1:0] dec_vec;

    // Slots freed by a same-cycle completion are not visible until the next cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_in[i] && (cnt_q[i] < MAX_CNT) && !hold_in && !flush_in;
        end
    end

    always_comb begin
        rr_elig  = eligible;
`ifdef PIPE_SLOT_ARB_PRIO0_EN
        rr_elig[0] = 1'b0;
`endif
        rr_found = 1'b0;
        rr_id    = '0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!rr_found && rr_elig[scan[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_id    = scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        issue_valid = 1'b0;
        issue_id    = '0;
        ptr_d       = ptr_q;
        ptr_nxt     = {1'b0, rr_id} + (IDW + 1)'(1);
        if (ptr_nxt == NUM_REQ_W) begin
            ptr_nxt = '0;
        end
`ifdef PIPE_SLOT_ARB_PRIO0_EN
        // Priority grants to requester 0 leave the rotation pointer alone.
        if (eligible[0]) begin
            issue_valid = 1'b1;
            issue_id    = '0;
        end else if (rr_found) begin
            issue_valid = 1'b1;
            issue_id    = rr_id;
            ptr_d       = ptr_nxt[IDW-1:0];
        end
`else
        if (rr_found) begin
            issue_valid = 1'b1;
            issue_id    = rr_id;
            ptr_d       = ptr_nxt[IDW-1:0];
        end
`endif
    end

    always_comb begin
        gnt_out = '0;
        if (issue_valid) begin
            gnt_out[issue_id] = 1'b1;
        end
    end

    assign issue_valid_out = issue_valid;
    assign issue_id_out    = issue_id;
    assign pipe_en_out     = ~hold_in;

    assign tail_id    = stage_id_q[LATENCY-1];
    assign done_valid = stage_vld_q[LATENCY-1] && !hold_in && !flush_in;

    always_comb begin
        done_out    = '0;
        done_id_out = '0;
        if (done_valid) begin
            done_out[tail_id] = 1'b1;
            done_id_out       = tail_id;
        end
    end

    assign busy_out = |stage_vld_q;

    // Flush wins over hold so that a held pipeline can still be emptied.
    always_comb begin
        stage_vld_d = stage_vld_q;
        for (int k = 0; k < LATENCY; k++) begin
            stage_id_d[k] = stage_id_q[k];
        end
        if (flush_in) begin
            stage_vld_d = '0;
        end else if (!hold_in) begin
            stage_vld_d[0] = issue_valid;
            stage_id_d[0]  = issue_id;
            for (int k = 1; k < LATENCY; k++) begin
                stage_vld_d[k] = stage_vld_q[k-1];
                stage_id_d[k]  = stage_id_q[k-1];
            end
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            inc_vec[i] = issue_valid && (issue_id == IDW'(i));
            dec_vec[i] = done_valid && (tail_id == IDW'(i));
            cnt_d[i]   = cnt_q[i];
            if (flush_in) begin
                cnt_d[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q       <= '0;
            stage_vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                stage_id_q[k] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            stage_vld_q <= stage_vld_d;
            for (int k = 0; k < LATENCY; k++) begin
                stage_id_q[k] <= stage_id_d[k];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_slot_arbiter.sv
// Directed bench for pipe_slot_arbiter at NUM_REQ=4, LATENCY=3, MAX_OUT=2 (round-robin build).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_pipe_slot_arbiter;

    logic       clk_in;
    logic       rst_n_in;
    logic [3:0] req_in;
    logic       hold_in;
    logic       flush_in;
    logic [3:0] gnt_out;
    logic       issue_valid_out;
    logic [1:0] issue_id_out;
    logic       pipe_en_out;
    logic [3:0] done_out;
    logic [1:0] done_id_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;

    pipe_slot_arbiter #(
        .NUM_REQ(4),
        .LATENCY(3),
        .MAX_OUT(2)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_in         (req_in),
        .hold_in        (hold_in),
        .flush_in       (flush_in),
        .gnt_out        (gnt_out),
        .issue_valid_out(issue_valid_out),
        .issue_id_out   (issue_id_out),
        .pipe_en_out    (pipe_en_out),
        .done_out       (done_out),
        .done_id_out    (done_id_out),
        .busy_out       (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [3:0] req, input logic hold, input logic flush);
        @(posedge clk_in);
        #1;
        req_in   = req;
        hold_in  = hold;
        flush_in = flush;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic [1:0] expIssueId,
                               input logic [3:0] expDone, input logic [1:0] expDoneId, input logic expBusy);
        logic expIssueValid;
        logic expPipeEn;
        expIssueValid = (expGnt != 4'b0000);
        expPipeEn     = ~hold_in;
        checks++;
        assert (gnt_out === expGnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt_out observed=%b expected=%b", tag, gnt_out, expGnt);
        end
        checks++;
        assert (issue_valid_out === expIssueValid) else begin
            errors++;
            $error("[TB] FAIL %s issue_valid_out observed=%b expected=%b", tag, issue_valid_out, expIssueValid);
        end
        checks++;
        assert (issue_id_out === expIssueId) else begin
            errors++;
            $error("[TB] FAIL %s issue_id_out observed=%0d expected=%0d", tag, issue_id_out, expIssueId);
        end
        checks++;
        assert (done_out === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done_out observed=%b expected=%b", tag, done_out, expDone);
        end
        checks++;
        assert (done_id_out === expDoneId) else begin
            errors++;
            $error("[TB] FAIL %s done_id_out observed=%0d expected=%0d", tag, done_id_out, expDoneId);
        end
        checks++;
        assert (busy_out === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy_out observed=%b expected=%b", tag, busy_out, expBusy);
        end
        checks++;
        assert (pipe_en_out === expPipeEn) else begin
            errors++;
            $error("[TB] FAIL %s pipe_en_out observed=%b expected=%b", tag, pipe_en_out, expPipeEn);
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        req_in   = 4'b0000;
        hold_in  = 1'b0;
        flush_in = 1'b0;
        #12;
        checkOutput("reset", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);
        #10;
        rst_n_in = 1'b1;

        // All four requesting: rotation 0,1,2,3,0,... with completions three cycles later.
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A0", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A1", 4'b0010, 2'd1, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A2", 4'b0100, 2'd2, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A3", 4'b1000, 2'd3, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A4", 4'b0001, 2'd0, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A5", 4'b0010, 2'd1, 4'b0100, 2'd2, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("A6", 4'b0100, 2'd2, 4'b1000, 2'd3, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("A7", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("A8", 4'b0000, 2'd0, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("A9", 4'b0000, 2'd0, 4'b0100, 2'd2, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("A10", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);

        // Single requester hits the in-flight cap; a freed slot is reusable only the cycle after.
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B0", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B1", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B2", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B3", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B4", 4'b0001, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B5", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("B6", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("B7", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("B8", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("B9", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);

        // Two held cycles stretch the issue-to-done latency from 3 to 5.
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("C0", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0); checkOutput("C1", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0); checkOutput("C2", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("C3", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("C4", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("C5", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("C6", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);

        // Hold while the op sits in the tail stage suppresses its completion until release.
        applyStimulus(4'b0001, 1'b0, 1'b0); checkOutput("H0", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("H1", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("H2", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0); checkOutput("H3", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("H4", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("H5", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);

        // Flush with three ops in flight: none of them completes and the counters restart at 0.
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("F0", 4'b0010, 2'd1, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("F1", 4'b0100, 2'd2, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("F2", 4'b1000, 2'd3, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b1); checkOutput("F3", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("F4", 4'b0010, 2'd1, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("F5", 4'b0010, 2'd1, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b0); checkOutput("F6", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("F7", 4'b0000, 2'd0, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("F8", 4'b0000, 2'd0, 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("F9", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset mid-burst: state clears at once and the pointer restarts at 0.
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("R0", 4'b0100, 2'd2, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("R1", 4'b1000, 2'd3, 4'b0000, 2'd0, 1'b1);
        #4;
        rst_n_in = 1'b0;
        req_in   = 4'b0000;
        #1;
        checkOutput("Rrst", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0);
        #1;
        rst_n_in = 1'b1;
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("R2", 4'b0001, 2'd0, 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0); checkOutput("R3", 4'b0010, 2'd1, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("R4", 4'b0000, 2'd0, 4'b0000, 2'd0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0); checkOutput("R5", 4'b0000, 2'd0, 4'b0001, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
